sbox_layer_seq: RTL and testbench
=================================

# sbox_layer_seq

Sequencer for the PRESENT substitution layer. It accepts a 64-bit cipher state over a valid/ready handshake and applies the S-box to all 16 nibbles using NIBBLES_PER_CYCLE shared sbox instances, one group per cycle. Lane 0 is also shared with the key-schedule requester, which needs one substituted nibble per round, through a fair arbiter. It sits between the round's addRoundKey stage and the pLayer in the encryption core.

## Interface
- NIBBLES_PER_CYCLE, 4: number of sbox lanes; legal values 1, 2, 4, 8, 16. Groups per layer: G = 16/NIBBLES_PER_CYCLE.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- in_valid_i  in  1  state_i is valid.
- in_ready_o  out  1  block can accept a state.
- state_i  in  64  state to substitute; nibble k is bits [4k+3:4k].
- out_valid_o  out  1  state_o holds a completed layer.
- out_ready_i  in  1  downstream accepts state_o.
- state_o  out  64  substituted state.
- key_req_i  in  1  key schedule requests one substitution.
- key_nib_i  in  4  nibble to substitute for the key schedule.
- key_ack_o  out  1  key request served this cycle.
- key_nib_o  out  4  S(key_nib_i); valid only when key_ack_o=1.
- busy_o  out  1  high in SUB or HOLD.

## Operation
- FSM states: IDLE, SUB, HOLD. Registers: work[63:0], grp counter (width clog2(G), minimum 1 bit), last_key flag.
- IDLE: in_ready_o=1. On in_valid_i&in_ready_o, load work←state_i, set grp=0, and go to SUB.
- SUB, layer cycle (key not granted): replace nibbles grp*P .. grp*P+P-1 of work with their S-box images, where P = NIBBLES_PER_CYCLE. Then grp++. If grp==G-1, go to HOLD.
- SUB, key cycle: the layer stalls (work and grp unchanged). Lane 0 input is muxed to key_nib_i.
- Arbitration:
  - key_ack_o = key_req_i & !(state==SUB & last_key).
  - last_key←key_ack_o when in SUB; cleared otherwise.
  - Result: in SUB, a continuous key request gets every other cycle, so the layer is never starved. In IDLE and HOLD the key is always granted.
- key_nib_o is combinational from key_nib_i through lane 0, with zero latency. A key request has no effect on work outside SUB.
- HOLD:
  - out_valid_o=1, state_o=work, held stable until out_ready_i.
  - On out_valid_o&out_ready_i, go to IDLE. No new input is accepted in the same cycle.
- state_o always drives work; it is meaningful only when out_valid_o=1.
- Reset values:
  - State IDLE, work=0, grp=0, last_key=0.
  - out_valid_o=0, in_ready_o=1, busy_o=0.
  - key_ack_o follows key_req_i.
- Reset mid-operation: the in-flight state is discarded and no out_valid_o is produced for it. in_ready_o=1 immediately, asynchronously.

## Timing
- Handshake in the cycle ending at edge 0. SUB occupies cycles 1..G with no key contention. out_valid_o is high from cycle G+1.
- With P=4, G=4: out_valid_o rises 5 cycles after acceptance.
- Each granted key cycle in SUB adds exactly 1 cycle of latency. Worst case with continuous key requests: 2G SUB cycles.
- Throughput: one state every G+2 cycles with out_ready_i held high.
- in_ready_o, out_valid_o and busy_o are decoded from registered FSM state, with no combinational path from inputs. key_ack_o and key_nib_o are combinational from key_req_i/key_nib_i and registered state.

## Structure
- Shared package present_pkg holds:
  - STATE_W=64 and NIB_N=16.
  - The FSM enum typedef seq_state_t {IDLE, SUB, HOLD}.
- Sub-module: the existing sbox, instantiated NIBBLES_PER_CYCLE times via generate. The lane 0 input mux (key versus layer) lives in this block.
- Group select uses an indexed part-select on work by grp; no per-nibble case logic.

## Test plan
- Reset, P=4, state_i=0x0000000000000000 → state_o=0xCCCCCCCCCCCCCCCC, with out_valid_o rising exactly 5 cycles after acceptance.
- state_i=0x0123456789ABCDEF → state_o=0xC56B90AD3EF84712, for each of P=1, 2, 4, 8, 16. Latency must be G+1 in each case.
- key_req_i held high through SUB with key_nib_i=0x7, P=4:
  - key_ack_o pattern in SUB is 1,0,1,0,…, and key_nib_o=0xD when acked.
  - Output arrives after 8 SUB cycles; value is unchanged from the no-key run.
- out_ready_i held low 10 cycles in HOLD → out_valid_o=1 and state_o stable throughout, in_ready_o=0, and a concurrent in_valid_i is not accepted.
- rst_i pulsed during the second SUB cycle → out_valid_o=0 and in_ready_o=1 during reset. The next state_i=0xFFFFFFFFFFFFFFFF then yields 0x2222222222222222.
- key_req_i in IDLE and HOLD with key_nib_i=0xA → key_ack_o=1 every cycle, key_nib_o=0xF, and HOLD data is unaffected.

Source files
------------

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared PRESENT constants and sequencer state type
// Contents: STATE_W (cipher state width), NIB_N (nibbles per state),
//           seq_state_t (substitution-layer sequencer states).
package present_pkg;
  localparam int STATE_W = 64;
  localparam int NIB_N   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } seq_state_t;
endpackage

// File: rtl/sbox_layer_seq_if.sv
// rtl/sbox_layer_seq_if.sv - state stream and key-request bundle of the sbox layer sequencer
// Signals: in_valid_i/in_ready_o/state_i (state in), out_valid_o/out_ready_i/state_o
//          (state out), key_req_i/key_nib_i/key_ack_o/key_nib_o (key-schedule lane 0
//          sharing), busy_o (layer in flight). master drives inputs, slave is the block.
interface sbox_layer_seq_if;
  import present_pkg::*;

  logic               in_valid_i;
  logic               in_ready_o;
  logic [STATE_W-1:0] state_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [STATE_W-1:0] state_o;
  logic               key_req_i;
  logic [3:0]         key_nib_i;
  logic               key_ack_o;
  logic [3:0]         key_nib_o;
  logic               busy_o;

  modport master (
    output in_valid_i, state_i, out_ready_i, key_req_i, key_nib_i,
    input  in_ready_o, out_valid_o, state_o, key_ack_o, key_nib_o, busy_o
  );

  modport slave (
    input  in_valid_i, state_i, out_ready_i, key_req_i, key_nib_i,
    output in_ready_o, out_valid_o, state_o, key_ack_o, key_nib_o, busy_o
  );
endinterface

// File: rtl/sbox.sv
// rtl/sbox.sv - PRESENT 4-bit S-box
// Ports: nib (input nibble), img (substituted nibble).
module sbox (
  input  logic [3:0] nib,
  output logic [3:0] img
);
  always_comb begin
    img = 4'h0;
    case (nib)
      4'h0: img = 4'hC;
      4'h1: img = 4'h5;
      4'h2: img = 4'h6;
      4'h3: img = 4'hB;
      4'h4: img = 4'h9;
      4'h5: img = 4'h0;
      4'h6: img = 4'hA;
      4'h7: img = 4'hD;
      4'h8: img = 4'h3;
      4'h9: img = 4'hE;
      4'hA: img = 4'hF;
      4'hB: img = 4'h8;
      4'hC: img = 4'h4;
      4'hD: img = 4'h7;
      4'hE: img = 4'h1;
      4'hF: img = 4'h2;
      default: img = 4'h0;
    endcase
  end
endmodule

// File: rtl/sbox_layer_seq_lanes.sv
// rtl/sbox_layer_seq_lanes.sv - NIBBLES_PER_CYCLE shared S-box lanes with key mux on lane 0
// Ports: lane_in/lane_out (one group of layer nibbles), key_sel (lane 0 serves the key
//        schedule this cycle), key_nib (key-schedule nibble). Lane 0 output doubles as
//        the key result.
module sbox_layer_seq_lanes #(
  parameter int NIBBLES_PER_CYCLE = 4
) (
  input  logic [4*NIBBLES_PER_CYCLE-1:0] lane_in,
  input  logic                           key_sel,
  input  logic [3:0]                     key_nib,
  output logic [4*NIBBLES_PER_CYCLE-1:0] lane_out
);
  logic [3:0] lane0_in;

  assign lane0_in = key_sel ? key_nib : lane_in[3:0];

  for (genvar i = 0; i < NIBBLES_PER_CYCLE; i++) begin : g_lane
    if (i == 0) begin : g_shared
      sbox u_sbox (.nib(lane0_in), .img(lane_out[3:0]));
    end else begin : g_layer
      sbox u_sbox (.nib(lane_in[4*i +: 4]), .img(lane_out[4*i +: 4]));
    end
  end
endmodule

// File: rtl/sbox_layer_seq.sv
// rtl/sbox_layer_seq.sv - PRESENT substitution-layer sequencer, one nibble group per cycle
// Ports: clk_i (rising-edge clock), rst_i (async active-high reset),
//        bus (sbox_layer_seq_if.slave: state in/out handshakes, key lane sharing, busy).
module sbox_layer_seq
  import present_pkg::*;
#(
  parameter int NIBBLES_PER_CYCLE = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sbox_layer_seq_if.slave   bus
);
  localparam int P      = NIBBLES_PER_CYCLE;
  localparam int G      = NIB_N / P;
  localparam int GRP_W  = (G > 1) ? $clog2(G) : 1;
  localparam int LANE_W = 4 * P;

  seq_state_t         state_q, state_d;
  logic [STATE_W-1:0] work_q;
  logic [GRP_W-1:0]   grp_q;
  logic               last_key_q;

  logic               key_ack;
  logic               layer_step;
  logic               last_grp;
  logic               in_ready, out_valid, busy;
  logic [LANE_W-1:0]  lane_in, lane_out;

  // Key is refused only right after a granted key cycle in SUB, so the
  // layer gets at least every other cycle under a continuous request.
  assign key_ack    = bus.key_req_i & ~((state_q == SUB) & last_key_q);
  assign layer_step = (state_q == SUB) & ~key_ack;
  assign last_grp   = (grp_q == GRP_W'(G - 1));
  assign lane_in    = work_q[grp_q*LANE_W +: LANE_W];

  sbox_layer_seq_lanes #(.NIBBLES_PER_CYCLE(P)) u_lanes (
    .lane_in (lane_in),
    .key_sel (key_ack),
    .key_nib (bus.key_nib_i),
    .lane_out(lane_out)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid_i) state_d = SUB;
      end
      SUB: begin
        busy = 1'b1;
        if (layer_step && last_grp) state_d = HOLD;
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      work_q     <= '0;
      grp_q      <= '0;
      last_key_q <= 1'b0;
    end else begin
      last_key_q <= (state_q == SUB) ? key_ack : 1'b0;
      if (state_q == IDLE && bus.in_valid_i) begin
        work_q <= bus.state_i;
        grp_q  <= '0;
      end else if (layer_step) begin
        work_q[grp_q*LANE_W +: LANE_W] <= lane_out;
        // Wrap to 0 on the last group so the part-select never leaves work.
        grp_q <= last_grp ? '0 : grp_q + GRP_W'(1);
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.busy_o      = busy;
  assign bus.state_o     = work_q;
  assign bus.key_ack_o   = key_ack;
  assign bus.key_nib_o   = lane_out[3:0];
endmodule

// File: tb/tb_sbox_layer_seq.sv
// tb/tb_sbox_layer_seq.sv - self-checking bench for sbox_layer_seq
module tb_sbox_layer_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc_cyc = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sbox_layer_seq_if bus ();
  sbox_layer_seq #(.NIBBLES_PER_CYCLE(4)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  // Width variants share one input stream, with output always ready and no key traffic.
  localparam int PV [4] = '{1, 2, 8, 16};
  logic        v_valid = 1'b0;
  logic [63:0] v_state = '0;
  logic [3:0]  v_ov;
  logic [63:0] v_so [4];

  for (genvar g = 0; g < 4; g++) begin : g_var
    sbox_layer_seq_if vb ();
    assign vb.in_valid_i  = v_valid;
    assign vb.state_i     = v_state;
    assign vb.out_ready_i = 1'b1;
    assign vb.key_req_i   = 1'b0;
    assign vb.key_nib_i   = 4'h0;
    sbox_layer_seq #(.NIBBLES_PER_CYCLE(PV[g])) u_var (.clk_i(clk), .rst_i(rst), .bus(vb));
    assign v_ov[g] = vb.out_valid_o;
    assign v_so[g] = vb.state_o;
  end

  function automatic logic [3:0] s4(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h2174_8FE3_DA09_B65C;  // nibble k holds S(k)
    return t[int'(x)*4 +: 4];
  endfunction

  function automatic logic [63:0] layer(input logic [63:0] s);
    logic [63:0] r;
    for (int k = 0; k < 16; k++) r[4*k +: 4] = s4(s[4*k +: 4]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a negedge; edge 0 is the accepting posedge.
  task automatic send(input logic [63:0] s);
    int n = 0;
    bus.in_valid_i = 1'b1;
    bus.state_i    = s;
    while (!bus.in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", bus.in_ready_o, 1'b1);
    sb.push_back(layer(s));
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat, input bit key_mode, input string tag);
    int n = 0;
    bit exp_ack = 1'b1;
    #1;
    while (!bus.out_valid_o && n < 40) begin
      if (key_mode) begin
        chk({tag, "_ack"}, bus.key_ack_o, exp_ack);
        if (exp_ack) chk({tag, "_knib"}, bus.key_nib_o, 4'hD);
        exp_ack = !exp_ack;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, cyc - acc_cyc + 1, exp_lat);
  endtask

  task automatic take(input string tag);
    logic [63:0] exp;
    if (sb.size() == 0) begin
      exp = 'x;
    end else begin
      exp = sb.pop_front();
    end
    chk({tag, "_data"}, bus.state_o, exp);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, "_idle_ov"}, bus.out_valid_o, 1'b0);
    chk({tag, "_idle_rdy"}, bus.in_ready_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat [4];
    logic [63:0] got [4];
    int vacc;
    logic [63:0] held;

    bus.in_valid_i  = 1'b0;
    bus.state_i     = '0;
    bus.out_ready_i = 1'b1;
    bus.key_req_i   = 1'b0;
    bus.key_nib_i   = 4'h0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_rdy", bus.in_ready_o, 1'b1);
    chk("rst_ov", bus.out_valid_o, 1'b0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_work", bus.state_o, 64'h0);
    chk("rst_ack0", bus.key_ack_o, 1'b0);
    bus.key_req_i = 1'b1;
    #1;
    chk("rst_ack1", bus.key_ack_o, 1'b1);
    bus.key_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All lane counts on the reference vector: latency G+1
    for (int g = 0; g < 4; g++) lat[g] = 0;
    v_valid = 1'b1;
    v_state = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    #1 vacc = cyc;
    @(negedge clk);
    v_valid = 1'b0;
    for (int n = 0; n < 25; n++) begin
      for (int g = 0; g < 4; g++) begin
        if (v_ov[g] && lat[g] == 0) begin
          lat[g] = cyc - vacc + 1;
          got[g] = v_so[g];
        end
      end
      @(negedge clk);
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("var_p%0d_lat", PV[g]), lat[g], 16 / PV[g] + 1);
      chk($sformatf("var_p%0d_data", PV[g]), got[g], 64'hC56B_90AD_3EF8_4712);
    end

    // Zero state, P=4
    send(64'h0);
    wait_out(5, 1'b0, "zero");
    chk("zero_const", bus.state_o, 64'hCCCC_CCCC_CCCC_CCCC);
    take("zero");

    // Reference vector, P=4
    send(64'h0123_4567_89AB_CDEF);
    wait_out(5, 1'b0, "ref4");
    take("ref4");

    // Continuous key request through SUB
    send(64'h0123_4567_89AB_CDEF);
    bus.key_req_i = 1'b1;
    bus.key_nib_i = 4'h7;
    wait_out(9, 1'b1, "keysub");
    bus.key_req_i = 1'b0;
    take("keysub");

    // Back-pressure in HOLD with key traffic and a concurrent input
    bus.out_ready_i = 1'b0;
    send(64'hFEDC_BA98_7654_3210);
    wait_out(5, 1'b0, "hold");
    held = bus.state_o;
    chk("hold_first", held, layer(64'hFEDC_BA98_7654_3210));
    bus.in_valid_i = 1'b1;
    bus.state_i    = 64'hDEAD_BEEF_0000_1111;
    bus.key_req_i  = 1'b1;
    bus.key_nib_i  = 4'hA;
    #1;
    for (int n = 0; n < 10; n++) begin
      chk("hold_ov", bus.out_valid_o, 1'b1);
      chk("hold_stable", bus.state_o, held);
      chk("hold_rdy", bus.in_ready_o, 1'b0);
      chk("hold_ack", bus.key_ack_o, 1'b1);
      chk("hold_knib", bus.key_nib_o, 4'hF);
      @(negedge clk);
    end
    bus.in_valid_i = 1'b0;
    take("hold");
    // IDLE: key always granted, nothing from the refused input appears
    for (int n = 0; n < 4; n++) begin
      chk("idle_ack", bus.key_ack_o, 1'b1);
      chk("idle_knib", bus.key_nib_o, 4'hF);
      chk("idle_ov", bus.out_valid_o, 1'b0);
      chk("idle_busy", bus.busy_o, 1'b0);
      @(negedge clk);
    end
    bus.key_req_i = 1'b0;

    // Reset during the second SUB cycle discards the layer
    send(64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ov", bus.out_valid_o, 1'b0);
    chk("midrst_rdy", bus.in_ready_o, 1'b1);
    chk("midrst_busy", bus.busy_o, 1'b0);
    sb.delete();
    @(negedge clk);
    chk("midrst_ov2", bus.out_valid_o, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    send(64'hFFFF_FFFF_FFFF_FFFF);
    wait_out(5, 1'b0, "after_rst");
    chk("after_rst_const", bus.state_o, 64'h2222_2222_2222_2222);
    take("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
